// File: rtl/pipe_seq_ctrl.sv
// Sequencer that plays a stored stimulus table into a two-stage datapath
// and checks each item as it comes out of the far end, three edges later.
module pipe_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_en,
  input  logic [2:0]   ld_addr,
  input  logic [W-1:0] ld_data,
  input  logic [3:0]   len,
  input  logic         start,
  output logic [W-1:0] dp_a,
  input  logic [W-1:0] dp_b,
  input  logic [W-1:0] dp_c,
  output logic         busy,
  output logic         done,
  output logic         mismatch,
  output logic [3:0]   err_cnt,
  output logic [2:0]   first_err_idx
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  state_t       state, state_n;
  logic [W-1:0] tbl [DEPTH];
  logic [3:0]   run_len;
  logic [3:0]   idx;
  logic         accept, issue, len_ok;
  logic [2:0]   issue_idx;
  logic [W-1:0] issue_val;

  logic [2:0]   pv;
  logic [W-1:0] pval [3];
  logic [2:0]   pidx [3];

  logic         unused_dp_b;
  assign unused_dp_b = ^dp_b;

  assign len_ok = (len != 4'd0) && (32'(len) <= DEPTH);

  // The table keeps its contents through reset; writes are locked out mid-run.
  always_ff @(posedge clk) begin
    if (ld_en && !busy && (32'(ld_addr) < DEPTH))
      tbl[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state)
      IDLE:  if (start && len_ok) begin
               state_n = DRIVE;
               accept  = 1'b1;
               issue   = 1'b1;
             end
      DRIVE: if (idx < run_len) issue = 1'b1;
             else               state_n = DRAIN;
      // The last item sits in the final stage once the two earlier stages are empty.
      DRAIN: if (!pv[0] && !pv[1]) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    issue_idx = accept ? 3'd0 : idx[2:0];
    issue_val = tbl[issue_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_a          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mismatch      <= 1'b0;
      err_cnt       <= 4'd0;
      first_err_idx <= 3'd0;
      run_len       <= 4'd0;
      idx           <= 4'd0;
      pv            <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        pval[i] <= '0;
        pidx[i] <= 3'd0;
      end
    end else begin
      busy     <= (state_n == DRIVE) || (state_n == DRAIN);
      done     <= (state == DRAIN) && (state_n == DONE);
      dp_a     <= issue ? issue_val : '0;
      mismatch <= pv[2] && (dp_c != pval[2]);

      pv      <= {pv[1:0], issue};
      pval[0] <= issue_val;
      pval[1] <= pval[0];
      pval[2] <= pval[1];
      pidx[0] <= issue_idx;
      pidx[1] <= pidx[0];
      pidx[2] <= pidx[1];

      if (pv[2] && (dp_c != pval[2])) begin
        err_cnt <= err_cnt + 4'd1;
        if (err_cnt == 4'd0) first_err_idx <= pidx[2];
      end

      if (accept) begin
        run_len       <= len;
        idx           <= 4'd1;
        err_cnt       <= 4'd0;
        first_err_idx <= 3'd0;
      end else if (issue) begin
        idx <= idx + 4'd1;
      end
    end
  end

endmodule
